// File: rtl/obs_capture.sv
// obs_capture: packs a sampled bit stream into words behind a one-entry holding register, and keeps a toggle count and a MISR signature
module obs_capture #(
    parameter int WORD_W = 8,
    parameter int CNT_W = 16,
    parameter logic [WORD_W-1:0] POLY = 8'h1D,
    parameter logic [WORD_W-1:0] SEED = '0
) (
    input  logic                         clkin_data,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         in_data,
    input  logic                         flush,
    input  logic                         out_ready,
    output logic                         out_valid,
    output logic [WORD_W-1:0]            out_data,
    output logic [$clog2(WORD_W+1)-1:0]  out_count,
    output logic                         overflow,
    output logic [CNT_W-1:0]             toggle_cnt,
    output logic [WORD_W-1:0]            signature
);
    localparam int PW = $clog2(WORD_W+1);

    logic [PW-1:0]     ptr;
    logic [PW-1:0]     cnt_next;
    logic [WORD_W-1:0] partial;
    logic [WORD_W-1:0] word;
    logic              prev_bit;
    logic              form;

    // Partial word including this edge's sample; a full word wins over a flush on the same edge
    always_comb begin
        cnt_next = ptr + PW'(en);
        for (int i = 0; i < WORD_W; i++)
            word[i] = (en && ptr == PW'(i)) ? in_data : partial[i];
        form = (cnt_next == PW'(WORD_W)) || (flush && cnt_next != '0);
    end

    // Bit packing: clear the assembly buffer whenever a word leaves it
    always_ff @(posedge clkin_data) begin
        if (rst) begin
            ptr <= '0;
            partial <= '0;
        end else begin
            ptr <= form ? '0 : cnt_next;
            partial <= form ? '0 : word;
        end
    end

    // Single-entry holding register; a word arriving while the entry is stuck is dropped and flagged
    always_ff @(posedge clkin_data) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data <= '0;
            out_count <= '0;
            overflow <= 1'b0;
        end else if (form) begin
            if (!out_valid || out_ready) begin
                out_valid <= 1'b1;
                out_data <= word;
                out_count <= cnt_next;
            end else begin
                overflow <= 1'b1;
            end
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Saturating count of transitions between consecutive samples
    always_ff @(posedge clkin_data) begin
        if (rst) begin
            prev_bit <= 1'b0;
            toggle_cnt <= '0;
        end else if (en) begin
            prev_bit <= in_data;
            if (in_data != prev_bit && toggle_cnt != '1)
                toggle_cnt <= toggle_cnt + CNT_W'(1);
        end
    end

    // MISR folds in every formed word, dropped ones included
    always_ff @(posedge clkin_data) begin
        if (rst)
            signature <= SEED;
        else if (form)
            signature <= {signature[WORD_W-2:0], 1'b0} ^ (signature[WORD_W-1] ? POLY : '0) ^ word;
    end
endmodule
